// File: rtl/vr16_control_unit.sv
// VR16 multi-cycle sequencer: fetch -> decode -> execute -> (mem) -> (writeback), owns pc and halt.
// Build option: define VR16_SINGLE_STEP_EN to add a 'step' input that gates each instruction fetch.
module vr16_control_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned PC_STEP  = 1
) (
    input  logic        clk,
    input  logic        reset,
`ifdef VR16_SINGLE_STEP_EN
    input  logic        step,
`endif
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    output logic [15:0] ir,
    input  logic [3:0]  opcode,
    input  logic [3:0]  imm_value,
    input  logic        zero_flag,
    output logic        alu_en,
    output logic        mem_req,
    output logic        mem_we,
    input  logic        mem_ack,
    output logic        rf_we,
    output logic [15:0] pc,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_LOAD  = 4'b1000;
    localparam logic [3:0] OP_STORE = 4'b1001;
    localparam logic [3:0] OP_LI    = 4'b1010;
    localparam logic [3:0] OP_JMP   = 4'b1011;
    localparam logic [3:0] OP_BEQ   = 4'b1100;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic        is_store_q, is_store_d;

    logic [15:0] pc_seq;
    logic [15:0] pc_rel;
    logic        op_is_alu;
    logic        op_is_mem;
    logic        fetch_enable;
    logic        fetch_done;

    assign pc_seq    = pc_q + 16'(PC_STEP);
    assign pc_rel    = pc_q + {{12{imm_value[3]}}, imm_value};
    assign op_is_alu = (opcode != OP_NOP) && (opcode[3] == 1'b0);
    assign op_is_mem = (opcode == OP_LOAD) || (opcode == OP_STORE);

`ifdef VR16_SINGLE_STEP_EN
    // A step pulse is remembered until the fetch it enables completes; a new pulse wins over the clear.
    logic step_pend_q, step_pend_d;

    assign fetch_enable = step_pend_q;
    assign step_pend_d  = step | (step_pend_q & ~fetch_done);

    always_ff @(posedge clk) begin
        if (!reset) begin
            step_pend_q <= 1'b0;
        end else begin
            step_pend_q <= step_pend_d;
        end
    end
`else
    assign fetch_enable = 1'b1;
`endif

    assign fetch_done = (state_q == S_FETCH) && fetch_enable && imem_ack;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            ir_q       <= 16'h0000;
            is_store_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            is_store_q <= is_store_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        is_store_d = is_store_q;
        case (state_q)
            S_FETCH: begin
                if (fetch_done) begin
                    ir_d    = imem_data;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                is_store_d = (opcode == OP_STORE);
                if (op_is_alu) begin
                    state_d = S_WRITEBACK;
                end else if (op_is_mem) begin
                    state_d = S_MEM;
                end else begin
                    case (opcode)
                        OP_LI: begin
                            state_d = S_WRITEBACK;
                        end
                        OP_JMP: begin
                            pc_d    = pc_rel;
                            state_d = S_FETCH;
                        end
                        OP_BEQ: begin
                            pc_d    = zero_flag ? pc_rel : pc_seq;
                            state_d = S_FETCH;
                        end
                        OP_HALT: begin
                            state_d = S_HALT;
                        end
                        default: begin
                            // NOP and the reserved opcodes just advance.
                            pc_d    = pc_seq;
                            state_d = S_FETCH;
                        end
                    endcase
                end
            end
            S_MEM: begin
                if (mem_ack) begin
                    if (is_store_q) begin
                        pc_d    = pc_seq;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end
            end
            S_WRITEBACK: begin
                pc_d    = pc_seq;
                state_d = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Output decode; only alu_en looks at the decoder's registered opcode.
    always_comb begin
        imem_req = 1'b0;
        alu_en   = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        rf_we    = 1'b0;
        halted   = 1'b0;
        case (state_q)
            S_FETCH:     imem_req = fetch_enable;
            S_EXECUTE:   alu_en   = op_is_alu | op_is_mem;
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = is_store_q;
            end
            S_WRITEBACK: rf_we    = 1'b1;
            S_HALT:      halted   = 1'b1;
            default: ;
        endcase
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign ir        = ir_q;

endmodule

// File: tb/tb_vr16_control_unit.sv
// Bench for vr16_control_unit: directed scenarios and a random instruction stream,
// each instruction checked against a per-instruction timing/pc model.
`timescale 1ns/1ps
module tb_vr16_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic [15:0] ir;
    logic [3:0]  opcode;
    logic [3:0]  imm_value;
    logic        zero_flag;
    logic        alu_en;
    logic        mem_req;
    logic        mem_we;
    logic        mem_ack;
    logic        rf_we;
    logic [15:0] pc;
    logic        halted;
`ifdef VR16_SINGLE_STEP_EN
    logic        step = 1'b1;
`endif

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] model_pc;

    always #5 clk = ~clk;

    vr16_control_unit dut (
        .clk       (clk),
        .reset     (reset),
`ifdef VR16_SINGLE_STEP_EN
        .step      (step),
`endif
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .ir        (ir),
        .opcode    (opcode),
        .imm_value (imm_value),
        .zero_flag (zero_flag),
        .alu_en    (alu_en),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_ack   (mem_ack),
        .rf_we     (rf_we),
        .pc        (pc),
        .halted    (halted)
    );

    // Decoder stand-in: registers the opcode and low-nibble immediate from ir.
    always_ff @(posedge clk) begin
        opcode    <= ir[15:12];
        imm_value <= ir[3:0];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Instruction-level model: next pc and the strobe/cycle profile of one instruction.
    task automatic ref_instr(input logic [15:0] cur_pc, input logic [15:0] instr, input logic zf,
                             input int mwait, output logic [15:0] npc, output int lat,
                             output int n_alu, output int n_rf, output int n_mem,
                             output bit we, output bit is_halt);
        int op;
        int off;
        int delta;
        op      = int'(instr[15:12]);
        off     = instr[3] ? int'(instr[3:0]) - 16 : int'(instr[3:0]);
        is_halt = (op == 15);
        delta   = 1;
        if (op == 11 || (op == 12 && zf)) delta = off;
        npc     = is_halt ? cur_pc : 16'(int'(cur_pc) + delta);
        n_alu   = (op >= 1 && op <= 9) ? 1 : 0;
        n_rf    = ((op >= 1 && op <= 7) || op == 8 || op == 10) ? 1 : 0;
        n_mem   = (op == 8 || op == 9) ? mwait + 1 : 0;
        we      = (op == 9);
        lat     = 3 + n_rf + n_mem;
    endtask

    // Entered at a negedge with the DUT in FETCH; leaves at the negedge of the next FETCH.
    task automatic run_instr(input logic [15:0] instr, input int fwait, input int mwait, input logic zf);
        logic [15:0] npc;
        logic [15:0] ir_before;
        int lat, e_alu, e_rf, e_mem;
        bit e_we, e_halt;
        int cyc, alu_cnt, alu_at, rf_cnt, rf_at, mem_cnt, we_bad, halt_cnt;
        ref_instr(model_pc, instr, zf, mwait, npc, lat, e_alu, e_rf, e_mem, e_we, e_halt);
        zero_flag = zf;
        alu_cnt = 0; alu_at = 0; rf_cnt = 0; rf_at = 0; mem_cnt = 0; we_bad = 0; halt_cnt = 0;
        chk("fetch_req", 32'(imem_req), 32'd1);
        chk("fetch_addr", 32'(imem_addr), 32'(model_pc));
        ir_before = ir;
        for (int i = 0; i < fwait; i++) begin
            imem_ack  = 1'b0;
            imem_data = 16'($urandom);
            @(negedge clk);
            chk("stall_req", 32'(imem_req), 32'd1);
            chk("stall_ir", 32'(ir), 32'(ir_before));
        end
        imem_ack  = 1'b1;
        imem_data = instr;
        @(negedge clk);
        imem_ack  = 1'b0;
        imem_data = 16'($urandom);
        chk("ir_load", 32'(ir), 32'(instr));
        cyc = 1;
        while (imem_req !== 1'b1 && cyc < 30) begin
            cyc++;
            if (alu_en === 1'b1) begin alu_cnt++; alu_at = cyc; end
            if (rf_we === 1'b1) begin rf_cnt++; rf_at = cyc; end
            if (halted === 1'b1) halt_cnt++;
            if (mem_req === 1'b1) begin
                mem_cnt++;
                if (mem_we !== e_we) we_bad++;
            end
            mem_ack = (mem_req === 1'b1) && (mem_cnt == mwait + 1);
            @(negedge clk);
        end
        mem_ack = 1'b0;
        chk("alu_count", 32'(alu_cnt), 32'(e_alu));
        chk("rf_count", 32'(rf_cnt), 32'(e_rf));
        chk("mem_cycles", 32'(mem_cnt), 32'(e_mem));
        chk("mem_we", 32'(we_bad), 32'd0);
        chk("pc_next", 32'(pc), 32'(npc));
        if (e_alu == 1) chk("alu_at", 32'(alu_at), 32'd3);
        if (e_halt) begin
            chk("halt_flag", 32'(halted), 32'd1);
            chk("halt_noreq", 32'(imem_req), 32'd0);
            chk("halt_cycles", 32'(halt_cnt >= 20), 32'd1);
        end else begin
            chk("latency", 32'(cyc), 32'(lat));
            chk("not_halted", 32'(halted), 32'd0);
            if (e_rf == 1) chk("rf_at", 32'(rf_at), 32'(lat));
        end
        $display("instr %h at pc %h -> pc %h, %0d cycles, alu %0d rf %0d mem %0d",
                 instr, model_pc, pc, cyc, alu_cnt, rf_cnt, mem_cnt);
        model_pc = npc;
    endtask

    initial begin
        logic [15:0] rnd_instr;
        int          guard;
        reset     = 1'b0;
        imem_ack  = 1'b1;
        imem_data = 16'hA5A5;
        mem_ack   = 1'b0;
        zero_flag = 1'b0;
        model_pc  = 16'h0000;

        // Reset hold with a stray ack that must not load ir.
        repeat (3) @(negedge clk);
        chk("rst_pc", 32'(pc), 32'h0000);
        chk("rst_ir", 32'(ir), 32'h0000);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_strobes", 32'({alu_en, rf_we, mem_req}), 32'd0);
        imem_ack = 1'b0;
        reset    = 1'b1;

        run_instr(16'h0000, 0, 0, 1'b0);
        run_instr(16'b0001_01_10_11_00_0000, 0, 0, 1'b0);
        chk("seq_pc", 32'(pc), 32'h0002);

        run_instr(16'h2345, 5, 0, 1'b0);

        // Walk pc to 0x0010, then the branch cases.
        run_instr(16'hB007, 0, 0, 1'b0);
        run_instr(16'hB006, 0, 0, 1'b0);
        chk("pc_at_10", 32'(pc), 32'h0010);
        run_instr(16'hB008, 0, 0, 1'b0);
        chk("jmp_back", 32'(pc), 32'h0008);
        run_instr(16'hC003, 0, 0, 1'b1);
        chk("beq_taken", 32'(pc), 32'h000B);
        run_instr(16'hB00D, 0, 0, 1'b0);
        run_instr(16'hC003, 0, 0, 1'b0);
        chk("beq_not_taken", 32'(pc), 32'h0009);

        run_instr(16'h8123, 0, 2, 1'b0);
        run_instr(16'h9456, 1, 1, 1'b0);
        run_instr(16'hA007, 0, 0, 1'b0);

        // Reset while a LOAD is waiting on mem_ack.
        imem_ack  = 1'b1;
        imem_data = 16'h8000;
        @(negedge clk);
        imem_ack = 1'b0;
        guard = 0;
        while (mem_req !== 1'b1 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        chk("mid_mem_reached", 32'(mem_req), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("mid_mem_memreq", 32'(mem_req), 32'd0);
        chk("mid_mem_pc", 32'(pc), 32'h0000);
        chk("mid_mem_fetch", 32'(imem_req), 32'd1);
        model_pc = 16'h0000;

        // pc wrap: jump to 0xFFFF then a NOP.
        run_instr(16'hB00F, 0, 0, 1'b0);
        chk("pc_ffff", 32'(pc), 32'hFFFF);
        run_instr(16'h0000, 0, 0, 1'b0);
        chk("pc_wrap", 32'(pc), 32'h0000);

        for (int k = 0; k < 40; k++) begin
            rnd_instr = {4'($urandom_range(0, 14)), 12'($urandom)};
            run_instr(rnd_instr, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                      1'($urandom));
        end

        run_instr(16'hF000, 0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
